// File: rtl/test_seq_pkg.sv
// Shared types, widths and helpers for the test-pattern sequencer.
package test_seq_pkg;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 23;
  localparam int unsigned CNT_W  = 6;

  localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWait,
    StCheck,
    StNext,
    StDone
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/test_seq_timeout.sv
// Per-handshake cycle counter; expired flags the TIMEOUT_CYC-th cycle spent waiting.
module test_seq_timeout #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LastCyc = 16'(TIMEOUT_CYC - 1);

  logic [15:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == LastCyc);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Walks the pattern ROM, loops each word through the DUT and tallies pass/fail.
// Define TEST_SEQ_LOOP_EN to add the `loop` input for continuous wrapping runs.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int unsigned NUM_TESTS   = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
`ifdef TEST_SEQ_LOOP_EN
  input  logic              loop,
`endif
  output logic [IDX_W-1:0]  current_test,
  input  logic [DATA_W-1:0] pattern,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [IDX_W-1:0]  first_fail,
  output logic              first_fail_vld,
  output logic              timeout_err
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_TESTS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic [IDX_W-1:0]  ff_q, ff_d;
  logic              ffv_q, ffv_d;
  logic              tmo_err_q, tmo_err_d;
  logic              wrap;

  logic tmo_clr, tmo_en, tmo_expired;

  assign tmo_en  = (state_q == StSend) || (state_q == StWait);
  assign tmo_clr = ((state_d == StSend) || (state_d == StWait)) && (state_d != state_q);

  test_seq_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    exp_d     = exp_q;
    rx_d      = rx_q;
    tx_data_d = tx_data_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ff_d      = ff_q;
    ffv_d     = ffv_q;
    tmo_err_d = tmo_err_q;
    wrap      = 1'b0;

    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StLoad;
            cur_d     = '0;
            pass_d    = '0;
            fail_d    = '0;
            ff_d      = '0;
            ffv_d     = 1'b0;
            tmo_err_d = 1'b0;
          end
        end
        StLoad: begin
          exp_d     = pattern;
          tx_data_d = pattern;
          state_d   = StSend;
        end
        StSend, StWait: begin
          if ((state_q == StSend) && tx_ready) begin
            state_d = StWait;
          end else if ((state_q == StWait) && rx_valid) begin
            rx_d    = rx_data;
            state_d = StCheck;
          end else if (tmo_expired) begin
            fail_d    = sat_inc(fail_q);
            tmo_err_d = 1'b1;
            if (!ffv_q) begin
              ff_d  = cur_q;
              ffv_d = 1'b1;
            end
            state_d = StNext;
          end
        end
        StCheck: begin
          if (rx_q == exp_q) begin
            pass_d = sat_inc(pass_q);
          end else begin
            fail_d = sat_inc(fail_q);
            if (!ffv_q) begin
              ff_d  = cur_q;
              ffv_d = 1'b1;
            end
          end
          state_d = StNext;
        end
        StNext: begin
          if (cur_q == LastIdx) begin
`ifdef TEST_SEQ_LOOP_EN
            if (loop) begin
              wrap    = 1'b1;
              cur_d   = '0;
              state_d = StLoad;
            end else begin
              state_d = StDone;
            end
`else
            state_d = StDone;
`endif
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = StLoad;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered off the next state so they line up with it.
    tx_valid_d = (state_d == StSend);
    busy_d     = (state_d != StIdle) && (state_d != StDone);
    done_d     = (state_d == StDone) || wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      exp_q      <= '0;
      rx_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      ff_q       <= '0;
      ffv_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      exp_q      <= exp_d;
      rx_q       <= rx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ff_q       <= ff_d;
      ffv_q      <= ffv_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign current_test   = cur_q;
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;
  assign timeout_err    = tmo_err_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench: pattern ROM plus a loopback DUT model with stall, flip and mute knobs.
module tb_test_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
`ifdef TEST_SEQ_LOOP_EN
  logic        loop;
`endif
  logic [4:0]  current_test;
  logic [22:0] pattern, tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid;
  logic        busy, done, first_fail_vld, timeout_err;
  logic [5:0]  pass_cnt, fail_cnt;
  logic [4:0]  first_fail;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  rdy_mode;   // 0 always ready, 1 never ready, 2 stall 3 cycles
  logic        flip_en, mute_en;
  int          stall_cnt;
  int          done_cnt, tv_cycles, unstable;
  logic [22:0] acc_log[$];
  logic        prev_vld;
  logic [22:0] prev_data;
  logic [22:0] exp_words[4];

  always #5 clk = ~clk;

  test_sequencer #(
    .NUM_TESTS  (4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
`ifdef TEST_SEQ_LOOP_EN
    .loop          (loop),
`endif
    .current_test  (current_test),
    .pattern       (pattern),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .busy          (busy),
    .done          (done),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .first_fail    (first_fail),
    .first_fail_vld(first_fail_vld),
    .timeout_err   (timeout_err)
  );

  always_comb begin
    pattern = 23'h0;
    case (current_test)
      5'd0:    pattern = 23'h7ABCDE;
      5'd1:    pattern = 23'h712345;
      5'd2:    pattern = 23'h767890;
      5'd3:    pattern = 23'h7BBCCD;
      default: pattern = 23'h0;
    endcase
  end

  assign tx_ready = (rdy_mode == 2'd0) ? 1'b1 :
                    (rdy_mode == 2'd1) ? 1'b0 : (stall_cnt >= 3);

  // Loopback DUT model; also fires a bogus readback mid-stall.
  always @(posedge clk) begin
    rx_valid <= 1'b0;
    if (!tx_valid) stall_cnt <= 0;
    else if (!tx_ready) stall_cnt <= stall_cnt + 1;
    if (tx_valid && tx_ready) begin
      if (!(mute_en && tx_data == 23'h712345)) begin
        rx_valid <= 1'b1;
        rx_data  <= (flip_en && tx_data == 23'h767890) ? (tx_data ^ 23'd1) : tx_data;
      end
    end else if (rdy_mode == 2'd2 && tx_valid && stall_cnt == 1) begin
      rx_valid <= 1'b1;
      rx_data  <= 23'h0;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (tx_valid) tv_cycles++;
    if (tx_valid && tx_ready) acc_log.push_back(tx_data);
    if (tx_valid && prev_vld && tx_data !== prev_data) unstable++;
    prev_vld  = tx_valid;
    prev_data = tx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_n"}, 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chk(tag, 32'(acc_log[i]), 32'(exp_words[i]));
  endtask

  initial begin
    exp_words = '{23'h7ABCDE, 23'h712345, 23'h767890, 23'h7BBCCD};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
`ifdef TEST_SEQ_LOOP_EN
    loop = 1'b0;
`endif
    rdy_mode = 2'd0; flip_en = 1'b0; mute_en = 1'b0;
    stall_cnt = 0; rx_valid = 1'b0; rx_data = '0;
    done_cnt = 0; tv_cycles = 0; unstable = 0; prev_vld = 1'b0; prev_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_idx", 32'(current_test), 32'd0);
    chk("rst_stats", {pass_cnt, fail_cnt, first_fail, first_fail_vld, timeout_err, done},
        32'd0);
    rst_n = 1'b1;

    // Clean loopback
    acc_log.delete(); done_cnt = 0;
    pulse_start();
    wait_done(100, "lb_done");
    chk("lb_pass", 32'(pass_cnt), 32'd4);
    chk("lb_fail", 32'(fail_cnt), 32'd0);
    chk("lb_ffv", 32'(first_fail_vld), 32'd0);
    chk("lb_tmo", 32'(timeout_err), 32'd0);
    @(negedge clk);
    chk("lb_busy", 32'(busy), 32'd0);
    chk_words("lb_word");
    repeat (3) @(negedge clk);
    chk("lb_done_cnt", 32'(done_cnt), 32'd1);

    // Bit 0 flipped on index 2
    flip_en = 1'b1;
    pulse_start();
    wait_done(100, "flip_done");
    chk("flip_pass", 32'(pass_cnt), 32'd3);
    chk("flip_fail", 32'(fail_cnt), 32'd1);
    chk("flip_ff", 32'(first_fail), 32'd2);
    chk("flip_ffv", 32'(first_fail_vld), 32'd1);
    flip_en = 1'b0;

    // Ready never rises: each index spends 8 cycles in SEND
    rdy_mode = 2'd1; tv_cycles = 0;
    pulse_start();
    wait_done(200, "tmo_done");
    chk("tmo_fail", 32'(fail_cnt), 32'd4);
    chk("tmo_pass", 32'(pass_cnt), 32'd0);
    chk("tmo_err", 32'(timeout_err), 32'd1);
    chk("tmo_ff", 32'(first_fail), 32'd0);
    chk("tmo_ffv", 32'(first_fail_vld), 32'd1);
    chk("tmo_send_cycles", 32'(tv_cycles), 32'd32);

    // 3-cycle ready stall with a spurious readback during SEND
    rdy_mode = 2'd2; tv_cycles = 0; unstable = 0; acc_log.delete();
    pulse_start();
    wait_done(200, "stall_done");
    chk("stall_pass", 32'(pass_cnt), 32'd4);
    chk("stall_fail", 32'(fail_cnt), 32'd0);
    chk("stall_tmo", 32'(timeout_err), 32'd0);
    chk("stall_unstable", 32'(unstable), 32'd0);
    chk("stall_send_cycles", 32'(tv_cycles), 32'd16);
    chk_words("stall_word");

    // Abort while waiting on index 1's readback
    rdy_mode = 2'd0; mute_en = 1'b1;
    repeat (2) @(negedge clk);
    done_cnt = 0;
    pulse_start();
    begin
      bit found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
        @(negedge clk);
        if (tx_valid && tx_ready && current_test == 5'd1) found = 1'b1;
      end
      chk("abort_reach_idx1", 32'(found), 32'd1);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pass", 32'(pass_cnt), 32'd1);
    chk("abort_idx", 32'(current_test), 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    mute_en = 1'b0;
    pulse_start();
    chk("restart_pass", 32'(pass_cnt), 32'd0);
    chk("restart_idx", 32'(current_test), 32'd0);
    wait_done(100, "restart_done");
    chk("restart_pass_end", 32'(pass_cnt), 32'd4);

    // Asynchronous reset in SEND
    rdy_mode = 2'd1;
    pulse_start();
    @(negedge clk);
    chk("ar_txv_before", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_txv", 32'(tx_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_txd", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 2'd0;

`ifdef TEST_SEQ_LOOP_EN
    loop = 1'b1;
    pulse_start();
    wait_done(100, "loop_wrap1");
    chk("loop_busy", 32'(busy), 32'd1);
    chk("loop_idx0", 32'(current_test), 32'd0);
    chk("loop_pass4", 32'(pass_cnt), 32'd4);
    wait_done(100, "loop_wrap2");
    chk("loop_pass8", 32'(pass_cnt), 32'd8);
    loop = 1'b0;
    wait_done(100, "loop_end");
    chk("loop_pass12", 32'(pass_cnt), 32'd12);
    @(negedge clk);
    chk("loop_idle", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
